// File: rtl/y_alu_pkg.sv
// y_alu_pkg: constants and types shared by the operand-issue, ALU and EX stages.
package y_alu_pkg;
   localparam int WIDTH = 32;
   localparam int NREGS = 32;
   localparam int IDXW  = $clog2(NREGS);
   localparam int IMMW  = 16;
   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } alu_op_e;
   typedef enum logic {EMPTY, FULL} ostate_e;
endpackage

// File: rtl/y_regfile.sv
// y_regfile: NREGS x WIDTH register file, 2 read / 1 write, R0 hardwired to zero, write-first bypass.
module y_regfile #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   localparam int IW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    ra,
   input  logic [IW-1:0]    rb,
   output logic [WIDTH-1:0] rda,
   output logic [WIDTH-1:0] rdb,
   input  logic             we,
   input  logic [IW-1:0]    wa,
   input  logic [WIDTH-1:0] wd
);
   logic [WIDTH-1:0] mem [NREGS];
   always_ff @(posedge clk)
      if (reset)
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      else if (we && wa != '0)
         mem[wa] <= wd;
   // Bypass lets an instruction issue in the same cycle its source is written back.
   assign rda = ra == '0 ? '0 : (we && wa == ra) ? wd : mem[ra];
   assign rdb = rb == '0 ? '0 : (we && wa == rb) ? wd : mem[rb];
endmodule

// File: rtl/y_operand_issue.sv
// y_operand_issue: reads ALU operands from the register file and issues them through a one-entry valid/ready stage.
module y_operand_issue import y_alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   parameter int IMMW  = 16,
   localparam int IW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    rs,
   input  logic [IW-1:0]    rt,
   input  logic [IMMW-1:0]  imm,
   input  logic             use_imm,
   input  logic [2:0]       op_in,
   input  logic             wb_en,
   input  logic [IW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op
);
   logic [WIDTH-1:0] rda, rdb;
   ostate_e st;
   logic accept;
   y_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .clk(clk), .reset(reset),
      .ra(rs), .rb(rt), .rda(rda), .rdb(rdb),
      .we(wb_en), .wa(wb_addr), .wd(wb_data)
   );
   assign out_valid = st == FULL;
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   always_ff @(posedge clk)
      if (reset) begin
         st     <= EMPTY;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else begin
         if (accept) begin
            alu_a  <= rda;
            alu_b  <= use_imm ? {{(WIDTH-IMMW){imm[IMMW-1]}}, imm} : rdb;
            alu_op <= op_in;
         end
         st <= accept ? FULL : out_ready ? EMPTY : st;
      end
endmodule
